// File: rtl/sync_fifo_pkg.sv
// Shared constants and helpers for the sync_fifo block.
// Holds the default word and pointer widths and a depth helper.
package sync_fifo_pkg;

    localparam int unsigned DEF_BIT_WIDTH  = 8;
    localparam int unsigned DEF_ADDR_WIDTH = 4;

    // Number of storage entries addressed by an aw-bit index
    function automatic int unsigned fifo_depth(input int unsigned aw);
        return 32'd1 << aw;
    endfunction

    localparam int unsigned DEF_DEPTH = fifo_depth(DEF_ADDR_WIDTH);

endpackage

// File: rtl/sync_fifo_mem.sv
// Simple dual-port register array used as FIFO storage.
// Ports:
//   clk, rst              clock, async active-high reset (read register only)
//   we_i, waddr_i, wdata_i  synchronous write port
//   re_i, raddr_i          synchronous read port
//   rdata_o                registered read data, holds when re_i is low
module sync_fifo_mem
    import sync_fifo_pkg::*;
#(
    parameter int unsigned BIT_WIDTH  = DEF_BIT_WIDTH,
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [BIT_WIDTH-1:0]  wdata_i,
    input  logic                  re_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [BIT_WIDTH-1:0]  rdata_o
);

    localparam int unsigned DEPTH = fifo_depth(ADDR_WIDTH);

    logic [BIT_WIDTH-1:0] mem_q [DEPTH];
    logic [BIT_WIDTH-1:0] rdata_q;

    // Storage array is intentionally not reset
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Read register: loads only on an accepted read, otherwise holds
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read data.
// Ports:
//   clk, rst     clock, async active-high reset
//   w_cntrl      write request (dropped while full)
//   r_cntrl      read request (ignored while empty)
//   data_in      write word
//   data_out     registered read word, valid after the accepting edge
//   full, empty  occupancy flags, decoded from the registered pointers
//   level        occupancy 0..DEPTH, present only with SYNC_FIFO_LEVEL_EN
module sync_fifo
    import sync_fifo_pkg::*;
#(
    parameter int unsigned BIT_WIDTH  = DEF_BIT_WIDTH,
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  w_cntrl,
    input  logic                  r_cntrl,
    input  logic [BIT_WIDTH-1:0]  data_in,
    output logic [BIT_WIDTH-1:0]  data_out,
    output logic                  full,
    output logic                  empty
`ifdef SYNC_FIFO_LEVEL_EN
    ,
    output logic [ADDR_WIDTH:0]   level
`endif
);

    localparam int unsigned PTR_W = ADDR_WIDTH + 1;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic             wr_accept_c;
    logic             rd_accept_c;

    // Extra MSB distinguishes full from empty when low bits match
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]) &&
                   (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]);

    assign wr_accept_c = w_cntrl && !full;
    assign rd_accept_c = r_cntrl && !empty;

    // Pointer next-state
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_accept_c) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (rd_accept_c) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

`ifdef SYNC_FIFO_LEVEL_EN
    // Modulo-2^PTR_W difference is exact for 0..DEPTH
    assign level = wr_ptr_q - rd_ptr_q;
`endif

    sync_fifo_mem #(
        .BIT_WIDTH  (BIT_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk     (clk),
        .rst     (rst),
        .we_i    (wr_accept_c),
        .waddr_i (wr_ptr_q[ADDR_WIDTH-1:0]),
        .wdata_i (data_in),
        .re_i    (rd_accept_c),
        .raddr_i (rd_ptr_q[ADDR_WIDTH-1:0]),
        .rdata_o (data_out)
    );

endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo with a queue scoreboard and occupancy model.
module tb_sync_fifo;
    import sync_fifo_pkg::*;

    localparam int unsigned BW    = DEF_BIT_WIDTH;
    localparam int unsigned AW    = DEF_ADDR_WIDTH;
    localparam int unsigned DEPTH = DEF_DEPTH;

    logic          clk;
    logic          rst;
    logic          w_cntrl;
    logic          r_cntrl;
    logic [BW-1:0] data_in;
    logic [BW-1:0] data_out;
    logic          full;
    logic          empty;
`ifdef SYNC_FIFO_LEVEL_EN
    logic [AW:0]   level;
`endif

    int errors = 0;
    int checks = 0;

    logic [BW-1:0] sb_q [$];
    int            model_cnt = 0;
    logic [BW-1:0] model_out = '0;
    logic [BW-1:0] exp_word;

    sync_fifo dut (
        .clk      (clk),
        .rst      (rst),
        .w_cntrl  (w_cntrl),
        .r_cntrl  (r_cntrl),
        .data_in  (data_in),
        .data_out (data_out),
        .full     (full),
        .empty    (empty)
`ifdef SYNC_FIFO_LEVEL_EN
        ,
        .level    (level)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_flags(input string tag);
        check({tag, ".empty"}, 32'(empty), 32'(model_cnt == 0));
        check({tag, ".full"},  32'(full),  32'(model_cnt == int'(DEPTH)));
`ifdef SYNC_FIFO_LEVEL_EN
        check({tag, ".level"}, 32'(level), 32'(model_cnt));
`endif
    endtask

    // One clock cycle: drive, advance, update model, compare
    task automatic cyc(input logic w, input logic r, input logic [BW-1:0] d, input string tag);
        bit wr_acc;
        bit rd_acc;
        w_cntrl = w;
        r_cntrl = r;
        data_in = d;
        wr_acc = w && (model_cnt < int'(DEPTH));
        rd_acc = r && (model_cnt > 0);
        @(posedge clk);
        #1;
        if (rd_acc) begin
            model_out = sb_q.pop_front();
            model_cnt--;
        end
        if (wr_acc) begin
            sb_q.push_back(d);
            model_cnt++;
        end
        check({tag, ".data_out"}, 32'(data_out), 32'(model_out));
        check_flags(tag);
        w_cntrl = 1'b0;
        r_cntrl = 1'b0;
    endtask

    task automatic model_reset();
        sb_q.delete();
        model_cnt = 0;
        model_out = '0;
    endtask

    initial begin
        rst     = 1'b1;
        w_cntrl = 1'b0;
        r_cntrl = 1'b0;
        data_in = '0;

        // Reset held with random inputs
        for (int i = 0; i < 10; i++) begin
            w_cntrl = 1'($urandom);
            r_cntrl = 1'($urandom);
            data_in = BW'($urandom);
            @(posedge clk);
            #1;
            check("rst_hold.empty", 32'(empty), 32'd1);
            check("rst_hold.full", 32'(full), 32'd0);
            check("rst_hold.data_out", 32'(data_out), 32'd0);
        end
        w_cntrl = 1'b0;
        r_cntrl = 1'b0;
        rst = 1'b0;
        model_reset();
        cyc(1'b0, 1'b0, 8'h00, "idle0");

        // Ordered traffic on alternate cycles
        cyc(1'b1, 1'b0, 8'hA5, "ord_w0");
        cyc(1'b0, 1'b0, 8'h00, "ord_i0");
        cyc(1'b1, 1'b0, 8'h3C, "ord_w1");
        cyc(1'b0, 1'b0, 8'h00, "ord_i1");
        cyc(1'b1, 1'b0, 8'hFF, "ord_w2");
        cyc(1'b0, 1'b0, 8'h00, "ord_i2");
        cyc(1'b0, 1'b1, 8'h00, "ord_r0");
        check("ord_r0.val", 32'(data_out), 32'hA5);
        cyc(1'b0, 1'b0, 8'h00, "ord_i3");
        cyc(1'b0, 1'b1, 8'h00, "ord_r1");
        check("ord_r1.val", 32'(data_out), 32'h3C);
        cyc(1'b0, 1'b0, 8'h00, "ord_i4");
        cyc(1'b0, 1'b1, 8'h00, "ord_r2");
        check("ord_r2.val", 32'(data_out), 32'hFF);
        check("ord_r2.empty_now", 32'(empty), 32'd1);

        // Fill to full, overflow write dropped, drain
        for (int i = 0; i < int'(DEPTH); i++) cyc(1'b1, 1'b0, BW'(i), "fill_w");
        check("fill.full_now", 32'(full), 32'd1);
        cyc(1'b1, 1'b0, 8'hEE, "ovf_w");
        for (int i = 0; i < int'(DEPTH); i++) begin
            cyc(1'b0, 1'b1, 8'h00, "drain_r");
            check("drain.val", 32'(data_out), 32'(i));
        end

        // Underflow: read while empty holds data_out
        cyc(1'b0, 1'b1, 8'h00, "unf_r");
        check("unf.hold", 32'(data_out), 32'h0F);
        cyc(1'b1, 1'b0, 8'h11, "unf_w");
        cyc(1'b0, 1'b1, 8'h00, "unf_r2");
        check("unf.val", 32'(data_out), 32'h11);

        // Simultaneous with 4 queued
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, BW'(8'h30 + i), "sim_pre");
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 1'b1, BW'(8'h20 + i), "sim_rw");
            check("sim_rw.cnt_steady", 32'(model_cnt), 32'd4);
        end
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 8'h00, "sim_drain");
        check("sim_drain.last", 32'(data_out), 32'h24);

        // Simultaneous while full: read only
        for (int i = 0; i < int'(DEPTH); i++) cyc(1'b1, 1'b0, BW'(8'h40 + i), "simf_fill");
        cyc(1'b1, 1'b1, 8'hEE, "simf_rw");
        check("simf.val", 32'(data_out), 32'h40);
        check("simf.full_drop", 32'(full), 32'd0);
        for (int i = 0; i < int'(DEPTH) - 1; i++) cyc(1'b0, 1'b1, 8'h00, "simf_drain");
        check("simf.last", 32'(data_out), 32'h4F);

        // Simultaneous while empty: write only, no fall-through
        cyc(1'b1, 1'b1, 8'h55, "sime_rw");
        check("sime.no_fall", 32'(data_out), 32'h4F);
        check("sime.not_empty", 32'(empty), 32'd0);
        cyc(1'b0, 1'b1, 8'h00, "sime_r");
        check("sime.val", 32'(data_out), 32'h55);

        // Wrap: 40 write/read pairs, then a full level sweep
        for (int i = 0; i < 40; i++) begin
            cyc(1'b1, 1'b0, BW'(8'h80 + i), "wrap_w");
            cyc(1'b0, 1'b1, 8'h00, "wrap_r");
        end
        check("wrap.last", 32'(data_out), 32'hA7);
        for (int i = 0; i < int'(DEPTH); i++) cyc(1'b1, 1'b0, BW'(8'hC0 + i), "lvl_up");
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 8'h00, "lvl_down");

        // Async reset mid-cycle discards queued data
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("arst.empty", 32'(empty), 32'd1);
        check("arst.full", 32'(full), 32'd0);
        check("arst.data_out", 32'(data_out), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        cyc(1'b0, 1'b1, 8'h00, "post_rst_r");
        cyc(1'b1, 1'b0, 8'h77, "post_rst_w");
        cyc(1'b0, 1'b1, 8'h00, "post_rst_r2");
        check("post_rst.val", 32'(data_out), 32'h77);

        // Full reset from full state, before next edge
        for (int i = 0; i < int'(DEPTH); i++) cyc(1'b1, 1'b0, BW'(i), "arst2_fill");
        #2;
        rst = 1'b1;
        #1;
        check("arst2.full", 32'(full), 32'd0);
        check("arst2.empty", 32'(empty), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        cyc(1'b0, 1'b0, 8'h00, "final_idle");
        check("final.sb_drained", 32'(sb_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
